// File: rtl/key_serializer.sv
// Purpose : queues 48-bit candidate keys in a small FIFO and shifts each out MSB first, one bit per KEY_STB.
// Latency : a key accepted into an empty FIFO while idle is popped one edge later; its first bit is valid from that edge.
// Backpressure: KEY_IN_READY drops when the FIFO is full or the search is done; KEY_STB low holds the current bit.
//
// Ports:
//   CLK, RESETn               clock, asynchronous active-low reset
//   KEY_IN/_VALID/_READY      candidate key input with valid/ready handshake
//   SEARCH_DONE               single-cycle pulse: no more keys will come
//   KEY_STB                   consumer bit strobe
//   KEY_DATA/_VALID/_FIRST    serial output bit, valid flag, first-bit-of-frame flag
//   KEY_COUNT                 saturating count of frames fully shifted out
//   DONE                      search finished and all accepted keys shifted out
module key_serializer #(
   parameter int DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic [47:0] KEY_IN,
   input  logic        KEY_IN_VALID,
   output logic        KEY_IN_READY,
   input  logic        SEARCH_DONE,
   input  logic        KEY_STB,
   output logic        KEY_DATA,
   output logic        KEY_VALID,
   output logic        KEY_FIRST,
   output logic [15:0] KEY_COUNT,
   output logic        DONE
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      FINISHED = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [47:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;

   logic [47:0] shift_reg;
   logic [5:0]  bit_cnt;
   logic        last_bit;
   logic        search_done_seen;
   // Holds READY low until the first edge after reset release.
   logic        running;

   // Same index with differing wrap bits means the write pointer lapped the read pointer.
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fifo_empty = (wr_ptr == rd_ptr);

   // Registered full only: a pop this cycle does not reopen READY until the next cycle.
   assign KEY_IN_READY = running && !fifo_full && !search_done_seen;
   assign push         = KEY_IN_VALID && KEY_IN_READY;

   assign last_bit = (state == SHIFT) && KEY_STB && (bit_cnt == 6'd47);
   // Pop from idle, or back-to-back on the final strobe of a frame so there is no gap cycle.
   assign pop      = !fifo_empty && ((state == IDLE) || last_bit);

   // State register
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nxt = SHIFT;
            end else if (search_done_seen) begin
               state_nxt = FINISHED;
            end
         end
         SHIFT: begin
            if (last_bit && fifo_empty) begin
               state_nxt = IDLE;
            end
         end
         FINISHED: state_nxt = FINISHED;
         default:  state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      KEY_VALID = (state == SHIFT);
      KEY_DATA  = (state == SHIFT) && shift_reg[47];
      KEY_FIRST = (state == SHIFT) && (bit_cnt == 6'd0);
      DONE      = (state == FINISHED);
   end

   // FIFO storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= KEY_IN;
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         running          <= 1'b0;
         search_done_seen <= 1'b0;
      end else begin
         running <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (SEARCH_DONE) begin
            search_done_seen <= 1'b1;
         end
      end
   end

   // Shift datapath and frame counter
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         shift_reg <= '0;
         bit_cnt   <= '0;
         KEY_COUNT <= '0;
      end else begin
         if (pop) begin
            shift_reg <= mem[rd_ptr[AW-1:0]];
            bit_cnt   <= '0;
         end else if (last_bit) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
         end else if ((state == SHIFT) && KEY_STB) begin
            shift_reg <= {shift_reg[46:0], 1'b0};
            bit_cnt   <= bit_cnt + 6'd1;
         end
         if (last_bit && (KEY_COUNT != 16'hFFFF)) begin
            KEY_COUNT <= KEY_COUNT + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_key_serializer.sv
// Bench for key_serializer: randomized and directed scenarios against a queue-based model
// of accepted keys and the serial bit stream that should result from them.
module tb_key_serializer;

   logic        CLK;
   logic        RESETn;
   logic [47:0] KEY_IN;
   logic        KEY_IN_VALID;
   logic        KEY_IN_READY;
   logic        SEARCH_DONE;
   logic        KEY_STB;
   logic        KEY_DATA;
   logic        KEY_VALID;
   logic        KEY_FIRST;
   logic [15:0] KEY_COUNT;
   logic        DONE;

   int n_checks;
   int n_pass;

   logic [47:0] acc_q[$];
   logic        bits_q[$];
   logic        firsts_q[$];

   key_serializer #(.DEPTH(4)) dut (
      .CLK          (CLK),
      .RESETn       (RESETn),
      .KEY_IN       (KEY_IN),
      .KEY_IN_VALID (KEY_IN_VALID),
      .KEY_IN_READY (KEY_IN_READY),
      .SEARCH_DONE  (SEARCH_DONE),
      .KEY_STB      (KEY_STB),
      .KEY_DATA     (KEY_DATA),
      .KEY_VALID    (KEY_VALID),
      .KEY_FIRST    (KEY_FIRST),
      .KEY_COUNT    (KEY_COUNT),
      .DONE         (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [47:0] rand_key();
      logic [47:0] k;
      k[47:32] = 16'($urandom);
      k[31:0]  = $urandom;
      return k;
   endfunction

   // Reassemble frame i from the consumed bit stream, first bit is the MSB.
   function automatic logic [47:0] frame_at(int i);
      logic [47:0] f;
      f = '0;
      for (int b = 0; b < 48; b++) begin
         if (i * 48 + b < bits_q.size()) f[47-b] = bits_q[i*48+b];
      end
      return f;
   endfunction

   // Number of consumed bits whose FIRST flag disagrees with its position in the stream.
   function automatic int firsts_bad();
      int n;
      n = 0;
      for (int j = 0; j < firsts_q.size(); j++) begin
         if (firsts_q[j] !== ((j % 48) == 0)) n++;
      end
      return n;
   endfunction

   // One clock cycle: drive inputs at the falling edge, log what the coming rising edge consumes.
   task automatic step(input logic v, input logic [47:0] k, input logic stb, input logic sd);
      KEY_IN_VALID = v;
      KEY_IN       = k;
      KEY_STB      = stb;
      SEARCH_DONE  = sd;
      if (v && KEY_IN_READY) acc_q.push_back(k);
      if (KEY_VALID && stb) begin
         bits_q.push_back(KEY_DATA);
         firsts_q.push_back(KEY_FIRST);
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      KEY_IN_VALID = 1'b0;
      KEY_IN       = '0;
      KEY_STB      = 1'b0;
      SEARCH_DONE  = 1'b0;
      RESETn       = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESETn = 1'b1;
      @(negedge CLK);
      acc_q.delete();
      bits_q.delete();
      firsts_q.delete();
   endtask

   task automatic test_reset();
      KEY_IN_VALID = 1'b0;
      KEY_IN       = '0;
      KEY_STB      = 1'b0;
      SEARCH_DONE  = 1'b0;
      RESETn       = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_checks++;
      if ({KEY_IN_READY, KEY_VALID, KEY_FIRST, KEY_DATA, DONE} !== 5'b0)
         $display("FAIL reset_outputs: got %b need 00000", {KEY_IN_READY, KEY_VALID, KEY_FIRST, KEY_DATA, DONE});
      else n_pass++;
      n_checks++;
      if (KEY_COUNT !== 16'd0) $display("FAIL reset_count: got %0d need 0", KEY_COUNT);
      else n_pass++;
      RESETn = 1'b1;
      #1;
      n_checks++;
      if (KEY_IN_READY !== 1'b0) $display("FAIL ready_before_edge: got %b need 0", KEY_IN_READY);
      else n_pass++;
      @(negedge CLK);
      n_checks++;
      if (KEY_IN_READY !== 1'b1) $display("FAIL ready_after_release: got %b need 1", KEY_IN_READY);
      else n_pass++;
      acc_q.delete();
      bits_q.delete();
      firsts_q.delete();
   endtask

   task automatic test_single_key();
      logic [47:0] k;
      k = 48'hAD1AEAC63EE3;
      do_reset();
      step(1'b1, k, 1'b1, 1'b0);
      n_checks++;
      if (KEY_VALID !== 1'b0) $display("FAIL single_valid_at_accept: got %b need 0", KEY_VALID);
      else n_pass++;
      step(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if ({KEY_VALID, KEY_FIRST, KEY_DATA} !== 3'b111)
         $display("FAIL single_first_bit: got %b need 111", {KEY_VALID, KEY_FIRST, KEY_DATA});
      else n_pass++;
      for (int i = 0; i < 48; i++) step(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (bits_q.size() != 48 || frame_at(0) !== k)
         $display("FAIL single_frame: got %0d bits %h need 48 bits %h", bits_q.size(), frame_at(0), k);
      else n_pass++;
      n_checks++;
      if (firsts_bad() != 0) $display("FAIL single_first_flags: got %0d bad need 0", firsts_bad());
      else n_pass++;
      n_checks++;
      if (KEY_COUNT !== 16'd1 || KEY_VALID !== 1'b0)
         $display("FAIL single_count_idle: got count %0d valid %b need 1 0", KEY_COUNT, KEY_VALID);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [47:0] keys[5];
      int rdy_bad;
      int vcyc;
      int gaps;
      int frame_bad;
      logic ended;
      do_reset();
      rdy_bad = 0;
      for (int i = 0; i < 5; i++) begin
         keys[i] = rand_key();
         if (KEY_IN_READY !== 1'b1) rdy_bad++;
         step(1'b1, keys[i], 1'b0, 1'b0);
      end
      n_checks++;
      if (rdy_bad != 0) $display("FAIL b2b_ready_during_fill: got %0d low need 0", rdy_bad);
      else n_pass++;
      n_checks++;
      if (KEY_IN_READY !== 1'b0) $display("FAIL b2b_ready_after_5: got %b need 0", KEY_IN_READY);
      else n_pass++;
      for (int i = 0; i < 3; i++) step(1'b1, rand_key(), 1'b0, 1'b0);
      n_checks++;
      if (acc_q.size() != 5 || KEY_IN_READY !== 1'b0)
         $display("FAIL b2b_sixth_held: got %0d accepted ready %b need 5 0", acc_q.size(), KEY_IN_READY);
      else n_pass++;
      vcyc = 0;
      gaps = 0;
      ended = 1'b0;
      for (int i = 0; i < 260; i++) begin
         if (KEY_VALID === 1'b1) begin
            if (ended) gaps++;
            vcyc++;
         end else if (vcyc > 0) begin
            ended = 1'b1;
         end
         step(1'b0, '0, 1'b1, 1'b0);
      end
      n_checks++;
      if (vcyc != 240 || gaps != 0) $display("FAIL b2b_contiguous: got %0d cycles %0d gaps need 240 0", vcyc, gaps);
      else n_pass++;
      frame_bad = 0;
      for (int i = 0; i < 5; i++) if (frame_at(i) !== keys[i]) frame_bad++;
      n_checks++;
      if (frame_bad != 0 || firsts_bad() != 0)
         $display("FAIL b2b_order: got %0d bad frames %0d bad first flags need 0 0", frame_bad, firsts_bad());
      else n_pass++;
      n_checks++;
      if (KEY_COUNT !== 16'd5) $display("FAIL b2b_count: got %0d need 5", KEY_COUNT);
      else n_pass++;
   endtask

   task automatic test_strobe_toggle();
      logic [47:0] k;
      logic stb;
      logic pd;
      logic pf;
      int hold_bad;
      int early;
      int cyc;
      k = rand_key();
      do_reset();
      step(1'b1, k, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
      hold_bad = 0;
      early = 0;
      cyc = 0;
      while (bits_q.size() < 48 && cyc < 200) begin
         stb = (cyc % 2) == 0;
         pd = KEY_DATA;
         pf = KEY_FIRST;
         step(1'b0, '0, stb, 1'b0);
         if (!stb && (KEY_DATA !== pd || KEY_FIRST !== pf)) hold_bad++;
         if (bits_q.size() < 48 && KEY_COUNT !== 16'd0) early++;
         if (bits_q.size() == 47 && KEY_VALID !== 1'b1) early++;
         cyc++;
      end
      n_checks++;
      if (hold_bad != 0) $display("FAIL toggle_hold: got %0d changes while strobe low need 0", hold_bad);
      else n_pass++;
      n_checks++;
      if (early != 0) $display("FAIL toggle_early_end: got %0d early events need 0", early);
      else n_pass++;
      n_checks++;
      if (bits_q.size() != 48 || frame_at(0) !== k)
         $display("FAIL toggle_frame: got %0d bits %h need 48 bits %h", bits_q.size(), frame_at(0), k);
      else n_pass++;
      n_checks++;
      if (KEY_COUNT !== 16'd1 || KEY_VALID !== 1'b0)
         $display("FAIL toggle_count: got count %0d valid %b need 1 0", KEY_COUNT, KEY_VALID);
      else n_pass++;
   endtask

   task automatic test_search_done();
      logic [47:0] keys[3];
      int overlap;
      int frame_bad;
      int stuck_bad;
      int cyc;
      do_reset();
      for (int i = 0; i < 3; i++) keys[i] = rand_key();
      step(1'b1, keys[0], 1'b0, 1'b0);
      step(1'b1, keys[1], 1'b0, 1'b0);
      step(1'b1, keys[2], 1'b0, 1'b1);
      n_checks++;
      if (acc_q.size() != 3 || KEY_IN_READY !== 1'b0 || DONE !== 1'b0)
         $display("FAIL sd_same_cycle_accept: got %0d accepted ready %b done %b need 3 0 0",
                  acc_q.size(), KEY_IN_READY, DONE);
      else n_pass++;
      overlap = 0;
      cyc = 0;
      while (DONE !== 1'b1 && cyc < 400) begin
         step(1'b0, '0, 1'b1, 1'b0);
         if (DONE === 1'b1 && (KEY_VALID === 1'b1 || bits_q.size() != 144)) overlap++;
         cyc++;
      end
      n_checks++;
      if (DONE !== 1'b1) $display("FAIL sd_done_timeout: got done %b need 1", DONE);
      else n_pass++;
      n_checks++;
      if (overlap != 0) $display("FAIL sd_done_early: got %0d need 0", overlap);
      else n_pass++;
      frame_bad = 0;
      for (int i = 0; i < 3; i++) if (frame_at(i) !== keys[i]) frame_bad++;
      n_checks++;
      if (frame_bad != 0 || bits_q.size() != 144 || KEY_COUNT !== 16'd3)
         $display("FAIL sd_frames: got %0d bad %0d bits count %0d need 0 144 3", frame_bad, bits_q.size(), KEY_COUNT);
      else n_pass++;
      stuck_bad = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom), rand_key(), 1'($urandom), 1'($urandom));
         if (DONE !== 1'b1 || KEY_IN_READY !== 1'b0 || KEY_VALID !== 1'b0 || KEY_DATA !== 1'b0) stuck_bad++;
      end
      n_checks++;
      if (stuck_bad != 0 || acc_q.size() != 3 || KEY_COUNT !== 16'd3)
         $display("FAIL sd_finished_sticky: got %0d bad %0d accepted count %0d need 0 3 3",
                  stuck_bad, acc_q.size(), KEY_COUNT);
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      int vis;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, rand_key(), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (bits_q.size() != 20 || KEY_VALID !== 1'b1)
         $display("FAIL mid_setup: got %0d bits valid %b need 20 1", bits_q.size(), KEY_VALID);
      else n_pass++;
      RESETn = 1'b0;
      #1;
      n_checks++;
      if ({KEY_IN_READY, KEY_VALID, KEY_FIRST, KEY_DATA, DONE} !== 5'b0 || KEY_COUNT !== 16'd0)
         $display("FAIL mid_reset_outputs: got %b count %0d need 00000 0",
                  {KEY_IN_READY, KEY_VALID, KEY_FIRST, KEY_DATA, DONE}, KEY_COUNT);
      else n_pass++;
      @(negedge CLK);
      RESETn = 1'b1;
      vis = 0;
      for (int i = 0; i < 150; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         if (KEY_VALID !== 1'b0) vis++;
      end
      n_checks++;
      if (vis != 0 || KEY_COUNT !== 16'd0)
         $display("FAIL mid_no_frames: got %0d valid cycles count %0d need 0 0", vis, KEY_COUNT);
      else n_pass++;
   endtask

   task automatic test_random();
      int frame_bad;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 3) != 0, rand_key(), ($urandom % 4) != 0, 1'b0);
      end
      for (int i = 0; i < 48 * 6 + 20; i++) step(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (bits_q.size() != 48 * acc_q.size())
         $display("FAIL rand_bit_total: got %0d need %0d", bits_q.size(), 48 * acc_q.size());
      else n_pass++;
      frame_bad = 0;
      for (int i = 0; i < acc_q.size(); i++) if (frame_at(i) !== acc_q[i]) frame_bad++;
      n_checks++;
      if (frame_bad != 0) $display("FAIL rand_frames: got %0d bad of %0d need 0", frame_bad, acc_q.size());
      else n_pass++;
      n_checks++;
      if (firsts_bad() != 0) $display("FAIL rand_first_flags: got %0d bad need 0", firsts_bad());
      else n_pass++;
      n_checks++;
      if (KEY_COUNT !== 16'(acc_q.size()) || KEY_VALID !== 1'b0)
         $display("FAIL rand_count: got %0d valid %b need %0d 0", KEY_COUNT, KEY_VALID, acc_q.size());
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_single_key();
      test_back_to_back();
      test_strobe_toggle();
      test_search_done();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
